// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and geometry for the direct-mapped data cache.
// Holds the FSM state enum, array sizes and the address-field slice positions.
package dcache_pkg;

   localparam int NUM_LINES   = 8;
   localparam int BLOCK_BYTES = 4;
   localparam int TAG_W       = 3;
   localparam int INDEX_W     = 3;
   localparam int OFFSET_W    = 2;
   localparam int LINE_W      = BLOCK_BYTES * 8;

   localparam int TAG_MSB = 7;
   localparam int TAG_LSB = 5;
   localparam int IDX_MSB = 4;
   localparam int IDX_LSB = 2;
   localparam int OFF_MSB = 1;
   localparam int OFF_LSB = 0;

   typedef enum logic [1:0] {
      IDLE,
      WRITEBACK,
      FETCH,
      UPDATE
   } state_t;

endpackage

// File: rtl/dcache_array.sv
// dcache_array: valid/dirty/tag/data storage plus the combinational hit compare.
// Ports: CLK, RESET (sync, active-low), index/tag/offset lookup, wr_en/wr_byte
// store, fill_en/fill_data line refill; hit, rd_byte, line_data, line_tag, evict.
module dcache_array
   import dcache_pkg::*;
(
   input  logic                CLK,
   input  logic                RESET,
   input  logic [INDEX_W-1:0]  index,
   input  logic [TAG_W-1:0]    tag,
   input  logic [OFFSET_W-1:0] offset,
   input  logic                wr_en,
   input  logic [7:0]          wr_byte,
   input  logic                fill_en,
   input  logic [LINE_W-1:0]   fill_data,
   output logic                hit,
   output logic [7:0]          rd_byte,
   output logic [LINE_W-1:0]   line_data,
   output logic [TAG_W-1:0]    line_tag,
   output logic                evict
);

   logic [NUM_LINES-1:0] valid_q;
   logic [NUM_LINES-1:0] dirty_q;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [LINE_W-1:0]    data_q [NUM_LINES];

   assign line_data = data_q[index];
   assign line_tag  = tag_q[index];
   assign hit       = valid_q[index] && (tag_q[index] == tag);
   assign evict     = valid_q[index] && dirty_q[index];
   assign rd_byte   = line_data[{offset, 3'b000} +: 8];

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         valid_q <= '0;
         dirty_q <= '0;
         for (int i = 0; i < NUM_LINES; i++) tag_q[i] <= '0;
      end else if (fill_en) begin
         valid_q[index] <= 1'b1;
         dirty_q[index] <= 1'b0;
         tag_q[index]   <= tag;
      end else if (wr_en) begin
         dirty_q[index] <= 1'b1;
      end
   end

   // Data contents survive reset; only the metadata is cleared.
   always_ff @(posedge CLK) begin
      if (fill_en)
         data_q[index] <= fill_data;
      else if (wr_en)
         data_q[index][{offset, 3'b000} +: 8] <= wr_byte;
   end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: write-back, write-allocate direct-mapped cache controller.
// Ports: CLK, RESET (sync, active-low), CPU READ/WRITE/ADDRESS/WRITEDATA,
// READDATA/BUSYWAIT, memory MEM_* block interface, HIT_COUNT.
// Macro DCACHE_HIT_COUNT_EN builds the saturating hit counter; else HIT_COUNT=0.
module dcache_ctrl
   import dcache_pkg::*;
(
   input  logic        CLK,
   input  logic        RESET,
   input  logic        READ,
   input  logic        WRITE,
   input  logic [7:0]  ADDRESS,
   input  logic [7:0]  WRITEDATA,
   output logic [7:0]  READDATA,
   output logic        BUSYWAIT,
   output logic        MEM_READ,
   output logic        MEM_WRITE,
   output logic [5:0]  MEM_ADDRESS,
   output logic [31:0] MEM_WRITEDATA,
   input  logic [31:0] MEM_READDATA,
   input  logic        MEM_BUSYWAIT,
   output logic [7:0]  HIT_COUNT
);

   state_t state, next_state;

   logic              req;
   logic              hit;
   logic              evict;
   logic              wr_en;
   logic              fill_en;
   logic [7:0]        rd_byte;
   logic [LINE_W-1:0] line_data;
   logic [TAG_W-1:0]  line_tag;
   logic [LINE_W-1:0] fetch_buf;

   logic [TAG_W-1:0]    a_tag;
   logic [INDEX_W-1:0]  a_idx;
   logic [OFFSET_W-1:0] a_off;

   assign a_tag = ADDRESS[TAG_MSB:TAG_LSB];
   assign a_idx = ADDRESS[IDX_MSB:IDX_LSB];
   assign a_off = ADDRESS[OFF_MSB:OFF_LSB];

   assign req      = READ || WRITE;
   assign BUSYWAIT = req && !(state == IDLE && hit);
   assign READDATA = (READ && !BUSYWAIT) ? rd_byte : 8'h00;
   // READ wins when both are high, so a store only happens on a pure WRITE.
   assign wr_en    = (state == IDLE) && WRITE && !READ && hit;

   dcache_array u_array (
      .CLK       (CLK),
      .RESET     (RESET),
      .index     (a_idx),
      .tag       (a_tag),
      .offset    (a_off),
      .wr_en     (wr_en),
      .wr_byte   (WRITEDATA),
      .fill_en   (fill_en),
      .fill_data (fetch_buf),
      .hit       (hit),
      .rd_byte   (rd_byte),
      .line_data (line_data),
      .line_tag  (line_tag),
      .evict     (evict)
   );

   always_ff @(posedge CLK) begin
      if (!RESET) state <= IDLE;
      else        state <= next_state;
   end

   always_ff @(posedge CLK) begin
      if (state == FETCH && !MEM_BUSYWAIT) fetch_buf <= MEM_READDATA;
   end

   always_comb begin
      next_state    = state;
      MEM_READ      = 1'b0;
      MEM_WRITE     = 1'b0;
      MEM_ADDRESS   = '0;
      MEM_WRITEDATA = '0;
      fill_en       = 1'b0;
      unique case (state)
         IDLE: begin
            if (req && !hit) next_state = evict ? WRITEBACK : FETCH;
         end
         WRITEBACK: begin
            MEM_WRITE     = 1'b1;
            MEM_ADDRESS   = {line_tag, a_idx};
            MEM_WRITEDATA = line_data;
            if (!MEM_BUSYWAIT) next_state = FETCH;
         end
         FETCH: begin
            MEM_READ    = 1'b1;
            MEM_ADDRESS = ADDRESS[TAG_MSB:IDX_LSB];
            if (!MEM_BUSYWAIT) next_state = UPDATE;
         end
         UPDATE: begin
            fill_en    = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

`ifdef DCACHE_HIT_COUNT_EN
   state_t    prev_state;
   logic [7:0] hit_cnt;

   // The first hit after a refill is the completion of the miss, not a hit.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         prev_state <= IDLE;
         hit_cnt    <= 8'h00;
      end else begin
         prev_state <= state;
         if (state == IDLE && req && hit &&
             prev_state != UPDATE && hit_cnt != 8'hFF)
            hit_cnt <= hit_cnt + 8'h01;
      end
   end

   assign HIT_COUNT = hit_cnt;
`else
   assign HIT_COUNT = 8'h00;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed self-checking bench for dcache_ctrl.
// Memory model completes each block transfer after a fixed latency.
module tb_dcache_ctrl;

   logic        CLK;
   logic        RESET;
   logic        READ;
   logic        WRITE;
   logic [7:0]  ADDRESS;
   logic [7:0]  WRITEDATA;
   logic [7:0]  READDATA;
   logic        BUSYWAIT;
   logic        MEM_READ;
   logic        MEM_WRITE;
   logic [5:0]  MEM_ADDRESS;
   logic [31:0] MEM_WRITEDATA;
   logic [31:0] MEM_READDATA;
   logic        MEM_BUSYWAIT;
   logic [7:0]  HIT_COUNT;

   int errors = 0;
   int checks = 0;

   localparam int LAT = 2;
   int cnt = 0;
   logic [31:0] mem [64] = '{1: 32'hDDCCBBAA, 9: 32'h44332211, default: 32'h0};

`ifdef DCACHE_HIT_COUNT_EN
   localparam logic [7:0] HC_FULL = 8'hFF;
`else
   localparam logic [7:0] HC_FULL = 8'h00;
`endif

   dcache_ctrl dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .READ          (READ),
      .WRITE         (WRITE),
      .ADDRESS       (ADDRESS),
      .WRITEDATA     (WRITEDATA),
      .READDATA      (READDATA),
      .BUSYWAIT      (BUSYWAIT),
      .MEM_READ      (MEM_READ),
      .MEM_WRITE     (MEM_WRITE),
      .MEM_ADDRESS   (MEM_ADDRESS),
      .MEM_WRITEDATA (MEM_WRITEDATA),
      .MEM_READDATA  (MEM_READDATA),
      .MEM_BUSYWAIT  (MEM_BUSYWAIT),
      .HIT_COUNT     (HIT_COUNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (cnt < LAT);
   assign MEM_READDATA = MEM_READ ? mem[MEM_ADDRESS] : 32'h0;

   always @(posedge CLK) begin
      if (MEM_READ || MEM_WRITE) begin
         if (cnt >= LAT) begin
            cnt <= 0;
            if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
         end else begin
            cnt <= cnt + 1;
         end
      end else begin
         cnt <= 0;
      end
   end

   task automatic wait_ready(output int n);
      n = 0;
      while (BUSYWAIT && n < 40) begin
         @(negedge CLK);
         n++;
      end
   endtask

   task automatic drive(input logic r, input logic w,
                        input logic [7:0] a, input logic [7:0] d);
      @(posedge CLK);
      #1;
      READ = r;
      WRITE = w;
      ADDRESS = a;
      WRITEDATA = d;
   endtask

   task automatic test_reset;
      RESET = 1'b0;
      READ = 1'b0;
      WRITE = 1'b0;
      ADDRESS = 8'h00;
      WRITEDATA = 8'h00;
      repeat (3) @(posedge CLK);
      #1 RESET = 1'b1;
      @(negedge CLK);
      checks++;
      if (BUSYWAIT !== 1'b0) begin errors++;
         $display("FAIL reset_busywait: got %b want 0", BUSYWAIT); end
      checks++;
      if (MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0) begin errors++;
         $display("FAIL reset_mem: got rd=%b wr=%b want 0 0", MEM_READ, MEM_WRITE); end
      checks++;
      if (HIT_COUNT !== 8'h00) begin errors++;
         $display("FAIL reset_hitcount: got %h want 00", HIT_COUNT); end
      checks++;
      if (READDATA !== 8'h00) begin errors++;
         $display("FAIL reset_readdata: got %h want 00", READDATA); end
   endtask

   task automatic test_clean_miss;
      int n;
      drive(1'b1, 1'b0, 8'h05, 8'h00);
      @(negedge CLK);
      checks++;
      if (BUSYWAIT !== 1'b1 || READDATA !== 8'h00) begin errors++;
         $display("FAIL miss_c0: got bw=%b rd=%h want 1 00", BUSYWAIT, READDATA); end
      @(negedge CLK);
      checks++;
      if (MEM_READ !== 1'b1 || MEM_WRITE !== 1'b0 || MEM_ADDRESS !== 6'h01) begin errors++;
         $display("FAIL miss_fetch: got rd=%b wr=%b a=%h want 1 0 01",
                  MEM_READ, MEM_WRITE, MEM_ADDRESS); end
      wait_ready(n);
      checks++;
      if (n !== 4) begin errors++;
         $display("FAIL miss_latency: got %0d want 4", n); end
      checks++;
      if (READDATA !== 8'hBB || MEM_READ !== 1'b0) begin errors++;
         $display("FAIL miss_data: got %h mrd=%b want BB 0", READDATA, MEM_READ); end
   endtask

   task automatic test_write_hit;
      drive(1'b0, 1'b1, 8'h05, 8'h5A);
      @(negedge CLK);
      checks++;
      if (BUSYWAIT !== 1'b0 || READDATA !== 8'h00) begin errors++;
         $display("FAIL wr_hit: got bw=%b rd=%h want 0 00", BUSYWAIT, READDATA); end
      checks++;
      if (MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0) begin errors++;
         $display("FAIL wr_hit_mem: got rd=%b wr=%b want 0 0", MEM_READ, MEM_WRITE); end
      drive(1'b1, 1'b0, 8'h05, 8'h00);
      @(negedge CLK);
      checks++;
      if (BUSYWAIT !== 1'b0 || READDATA !== 8'h5A) begin errors++;
         $display("FAIL rd_after_wr: got bw=%b rd=%h want 0 5A", BUSYWAIT, READDATA); end
      drive(1'b1, 1'b0, 8'h04, 8'h00);
      @(negedge CLK);
      checks++;
      if (READDATA !== 8'hAA) begin errors++;
         $display("FAIL rd_byte0: got %h want AA", READDATA); end
      drive(1'b0, 1'b0, 8'h05, 8'h00);
      @(negedge CLK);
      checks++;
      if (READDATA !== 8'h00) begin errors++;
         $display("FAIL rd_idle_zero: got %h want 00", READDATA); end
   endtask

   task automatic test_dirty_miss;
      int n;
      drive(1'b1, 1'b0, 8'h25, 8'h00);
      @(negedge CLK);
      @(negedge CLK);
      checks++;
      if (MEM_WRITE !== 1'b1 || MEM_READ !== 1'b0 || MEM_ADDRESS !== 6'h01) begin errors++;
         $display("FAIL wb_ctrl: got wr=%b rd=%b a=%h want 1 0 01",
                  MEM_WRITE, MEM_READ, MEM_ADDRESS); end
      checks++;
      if (MEM_WRITEDATA !== 32'hDDCC5AAA) begin errors++;
         $display("FAIL wb_data: got %h want DDCC5AAA", MEM_WRITEDATA); end
      repeat (3) @(negedge CLK);
      checks++;
      if (MEM_READ !== 1'b1 || MEM_WRITE !== 1'b0 || MEM_ADDRESS !== 6'h09) begin errors++;
         $display("FAIL wb_fetch: got rd=%b wr=%b a=%h want 1 0 09",
                  MEM_READ, MEM_WRITE, MEM_ADDRESS); end
      wait_ready(n);
      checks++;
      if (n !== 4 || READDATA !== 8'h22) begin errors++;
         $display("FAIL dirty_done: got n=%0d rd=%h want 4 22", n, READDATA); end
      drive(1'b1, 1'b0, 8'h05, 8'h00);
      @(negedge CLK);
      @(negedge CLK);
      checks++;
      if (MEM_READ !== 1'b1 || MEM_WRITE !== 1'b0) begin errors++;
         $display("FAIL refetch_clean: got rd=%b wr=%b want 1 0", MEM_READ, MEM_WRITE); end
      wait_ready(n);
      checks++;
      if (n !== 4 || READDATA !== 8'h5A) begin errors++;
         $display("FAIL refetch_data: got n=%0d rd=%h want 4 5A", n, READDATA); end
   endtask

   task automatic test_reset_mid_fetch;
      int n;
      drive(1'b1, 1'b0, 8'h45, 8'h00);
      @(negedge CLK);
      @(negedge CLK);
      checks++;
      if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 6'h11) begin errors++;
         $display("FAIL rst_fetch: got rd=%b a=%h want 1 11", MEM_READ, MEM_ADDRESS); end
      RESET = 1'b0;
      @(negedge CLK);
      checks++;
      if (MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0) begin errors++;
         $display("FAIL rst_abandon: got rd=%b wr=%b want 0 0", MEM_READ, MEM_WRITE); end
      @(posedge CLK);
      #1;
      RESET = 1'b1;
      READ = 1'b0;
      drive(1'b1, 1'b0, 8'h05, 8'h00);
      @(negedge CLK);
      checks++;
      if (BUSYWAIT !== 1'b1) begin errors++;
         $display("FAIL rst_miss: got bw=%b want 1", BUSYWAIT); end
      @(negedge CLK);
      checks++;
      if (MEM_READ !== 1'b1 || MEM_WRITE !== 1'b0) begin errors++;
         $display("FAIL rst_no_wb: got rd=%b wr=%b want 1 0", MEM_READ, MEM_WRITE); end
      wait_ready(n);
      checks++;
      if (n !== 4 || READDATA !== 8'h5A) begin errors++;
         $display("FAIL rst_refill: got n=%0d rd=%h want 4 5A", n, READDATA); end
   endtask

   task automatic test_read_write_both;
      int n;
      drive(1'b1, 1'b1, 8'h05, 8'hFF);
      @(negedge CLK);
      checks++;
      if (BUSYWAIT !== 1'b0 || READDATA !== 8'h5A) begin errors++;
         $display("FAIL rw_both: got bw=%b rd=%h want 0 5A", BUSYWAIT, READDATA); end
      drive(1'b1, 1'b0, 8'h05, 8'h00);
      @(negedge CLK);
      checks++;
      if (READDATA !== 8'h5A) begin errors++;
         $display("FAIL rw_unchanged: got %h want 5A", READDATA); end
      drive(1'b1, 1'b0, 8'h25, 8'h00);
      @(negedge CLK);
      @(negedge CLK);
      checks++;
      if (MEM_WRITE !== 1'b0 || MEM_READ !== 1'b1) begin errors++;
         $display("FAIL rw_still_clean: got wr=%b rd=%b want 0 1", MEM_WRITE, MEM_READ); end
      wait_ready(n);
      checks++;
      if (n !== 4 || READDATA !== 8'h22) begin errors++;
         $display("FAIL rw_refill: got n=%0d rd=%h want 4 22", n, READDATA); end
   endtask

   task automatic test_hit_count;
      repeat (300) @(negedge CLK);
      checks++;
      if (BUSYWAIT !== 1'b0 || READDATA !== 8'h22) begin errors++;
         $display("FAIL hc_hits: got bw=%b rd=%h want 0 22", BUSYWAIT, READDATA); end
      checks++;
      if (HIT_COUNT !== HC_FULL) begin errors++;
         $display("FAIL hc_value: got %h want %h", HIT_COUNT, HC_FULL); end
      drive(1'b0, 1'b0, 8'h00, 8'h00);
   endtask

   initial begin
      test_reset;
      test_clean_miss;
      test_write_hit;
      test_dirty_miss;
      test_reset_mid_fetch;
      test_read_write_both;
      test_hit_count;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-low. Ports CLK and RESET; RESET=0 resets on a CLK rising edge.
REQ-002 CLK  in  1  system clock; all state updates on the rising edge.
REQ-003 RESET  in  1  synchronous active-low reset.
REQ-004 READ / WRITE  in  1 each  CPU load / store request, held until BUSYWAIT is low.
REQ-005 ADDRESS  in  8  CPU byte address: tag[7:5], index[4:2], offset[1:0].
REQ-006 WRITEDATA  in  8  store data.
REQ-007 READDATA  out  8  load data.
REQ-008 BUSYWAIT  out  1  CPU stall request.
REQ-009 MEM_READ / MEM_WRITE  out  1 each  main-memory block read / write.
REQ-010 MEM_ADDRESS  out  6  block address {tag,index}.
REQ-011 MEM_WRITEDATA  out  32  evicted block, byte 0 in [7:0].
REQ-012 MEM_READDATA  in  32  fetched block, byte 0 in [7:0].
REQ-013 MEM_BUSYWAIT  in  1  memory busy; a transfer completes on the first edge it is seen low while MEM_READ or MEM_WRITE is high.
REQ-014 HIT_COUNT  out  8  hit counter (see Configuration).

Function
REQ-015 Storage: direct-mapped, 8 lines x 4 bytes; per line valid bit, dirty bit and 3-bit tag; write-back, write-allocate.
REQ-016 hit = valid[index] && tag[index]==ADDRESS[7:5], evaluated combinationally.
REQ-017 FSM states: IDLE, WRITEBACK, FETCH, UPDATE.
REQ-018 BUSYWAIT = (READ||WRITE) && !(state==IDLE && hit), combinational.
REQ-019 Read hit: READDATA = selected byte in the same cycle; BUSYWAIT=0; zero latency.
REQ-020 Write hit: byte written and dirty set at the next edge; BUSYWAIT=0.
REQ-021 READDATA SHALL be 8'h00 whenever READ=0 or BUSYWAIT=1.
REQ-022 On a miss in IDLE: go to WRITEBACK if valid&&dirty, else go to FETCH.
REQ-023 WRITEBACK: MEM_WRITE=1, MEM_ADDRESS={old tag,index}, MEM_WRITEDATA=line; go to FETCH when the transfer completes.
REQ-024 FETCH: MEM_READ=1, MEM_ADDRESS=ADDRESS[7:2]; go to UPDATE when the transfer completes, capturing MEM_READDATA.
REQ-025 UPDATE, 1 cycle: line<=fetched data, tag<=ADDRESS[7:5], valid<=1, dirty<=0; next state IDLE, where the request then hits per REQ-019/020.
REQ-026 Outside WRITEBACK and FETCH: MEM_READ=MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0.
REQ-027 READ and WRITE both high: treated as READ; no store is performed.
REQ-028 Request dropped mid-miss: the current memory transfer and UPDATE complete, then the FSM returns to IDLE; no CPU write occurs.
REQ-029 Hit latency 0 cycles. Clean-miss latency = memory read time + 1 cycle. Dirty-miss latency = memory write time + memory read time + 1 cycle.

Reset
REQ-030 RESET=0 at an edge: state<=IDLE; all valid, dirty and tags cleared; HIT_COUNT<=0. Data arrays are not cleared.
REQ-031 Reset mid-miss: the transfer is abandoned, MEM_READ and MEM_WRITE are low from the next cycle, and no writeback is issued.

Configuration
REQ-032 Macro DCACHE_HIT_COUNT_EN defined: HIT_COUNT increments, saturating at 255, on each cycle in IDLE where (READ||WRITE) && hit and the previous state was not UPDATE.
REQ-033 DCACHE_HIT_COUNT_EN undefined: HIT_COUNT is tied to 8'h00, no counter logic is built, and the port list is unchanged.

Structure
REQ-034 Shared package dcache_pkg SHALL hold: the state enumeration; constants for line count (8), block bytes (4), tag width (3), index width (3) and offset width (2); and the address-field slice positions.
REQ-035 One sub-module, dcache_array, SHALL hold the valid/dirty/tag/data arrays and the hit compare; dcache_ctrl holds the FSM, the memory interface and the counter.

Verification
REQ-036 Reset, then READ ADDRESS=8'h05 with the memory returning 32'hDDCCBBAA -> FETCH with MEM_ADDRESS=6'h01, UPDATE, then READDATA=8'hBB with BUSYWAIT low.
REQ-037 WRITE 8'h5A to 8'h05, then READ 8'h05 -> both hit, READDATA=8'h5A, no MEM_READ or MEM_WRITE.
REQ-038 After REQ-037, READ 8'h25 (same index, tag 1) -> WRITEBACK with MEM_ADDRESS=6'h01 and MEM_WRITEDATA=32'hDDCC5AAA, then FETCH with MEM_ADDRESS=6'h09.
REQ-039 RESET=0 during FETCH -> MEM_READ low the next cycle; a subsequent READ 8'h05 misses.
REQ-040 READ and WRITE both high on a hit line -> read data returned, line unchanged, dirty bit unchanged.
REQ-041 With DCACHE_HIT_COUNT_EN defined, 300 hit cycles -> HIT_COUNT=255; with it undefined -> HIT_COUNT=0.
